// File: rtl/serial_addsub_ov.sv
// serial_addsub_ov
//   Bit-serial two's-complement adder/subtractor with a registered signed
//   overflow flag. One result bit is produced per clock, LSB first.
//
//   Handshake: start is a request sampled only while idle. Once accepted,
//   busy stays high for WIDTH cycles and start is ignored. done then pulses
//   high for exactly one cycle. From that cycle on, result and ov hold the
//   completed operation until the next accepted start. There is no
//   back-pressure on done. Holding start high gives one operation every
//   WIDTH+2 cycles.
//
//   Parameters:
//     WIDTH   operand/result width in bits (2..32)
//   Ports:
//     clk     system clock, rising edge
//     rst     asynchronous active-high reset
//     start   request a new operation (sampled in IDLE only)
//     a, b    signed operands, captured on the accepted start edge
//     s       0 = a+b, 1 = a-b, captured on the accepted start edge
//     busy    high while bits are being processed
//     done    one-cycle completion pulse
//     result  sum/difference modulo 2^WIDTH
//     ov      signed overflow of the last completed operation
module serial_addsub_ov #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             ov
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] op_a_q;
  logic [WIDTH-1:0] op_b_q;
  logic             c_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] result_q;
  logic             ov_q;

  logic sum_bit;
  logic carry_out;

  // One full-adder slice on the current LSBs.
  always_comb begin
    sum_bit   = op_a_q[0] ^ op_b_q[0] ^ c_q;
    carry_out = (op_a_q[0] & op_b_q[0]) | (op_a_q[0] & c_q) | (op_b_q[0] & c_q);
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (cnt_q == LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath. Subtraction is a + ~b + 1: b is inverted at capture and the
  // +1 rides in as the initial carry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a_q   <= '0;
      op_b_q   <= '0;
      c_q      <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      ov_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            op_a_q <= a;
            op_b_q <= s ? ~b : b;
            c_q    <= s;
            cnt_q  <= '0;
          end
        end
        SHIFT: begin
          result_q <= {sum_bit, result_q[WIDTH-1:1]};
          op_a_q   <= {1'b0, op_a_q[WIDTH-1:1]};
          op_b_q   <= {1'b0, op_b_q[WIDTH-1:1]};
          c_q      <= carry_out;
          cnt_q    <= cnt_q + CW'(1);
          // Signed overflow: carry into the MSB differs from carry out of it.
          if (cnt_q == LAST) begin
            ov_q <= c_q ^ carry_out;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy   = (state_q == SHIFT);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign ov     = ov_q;

endmodule

// File: tb/tb_serial_addsub_ov.sv
// tb_serial_addsub_ov
//   Bench for serial_addsub_ov at WIDTH=8: reset values, a table of directed
//   vectors, randomized operations against an integer reference model,
//   start-ignored-while-busy, asynchronous reset mid-operation, and
//   back-to-back operation with start held high.
module tb_serial_addsub_ov;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         s;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         ov;

  int total;
  int bad;

  logic [W:0] exp_q[$];

  serial_addsub_ov #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .s      (s),
    .busy   (busy),
    .done   (done),
    .result (result),
    .ov     (ov)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached (act=running exp=finished)");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: act=0x%0h exp=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: true signed arithmetic on integers.
  function automatic logic [W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                       input logic ms);
    int sa;
    int sb;
    int t;
    logic [31:0] tv;
    logic o;
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    t  = ms ? (sa - sb) : (sa + sb);
    tv = t;
    o  = (t > (2 ** (W - 1)) - 1) || (t < -(2 ** (W - 1)));
    return {o, tv[W-1:0]};
  endfunction

  // ---------------- driver ----------------
  // Called at a negedge with the DUT idle; returns at a negedge with the DUT
  // idle again.
  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic is,
                        output logic [W-1:0] r, output logic o);
    int  busy_cnt;
    bit  seen;
    a = ia; b = ib; s = is; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_cnt = 0;
    seen = 1'b0;
    for (int i = 0; i < W + 6; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) busy_cnt++;
      @(negedge clk);
    end
    check("done_seen", 32'(seen), 32'd1);
    check("busy_cycles", 32'(busy_cnt), 32'(W));
    r = result;
    o = ov;
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
  endtask

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vs;
    logic [W-1:0] exp_r;
    logic         exp_o;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [W-1:0] r;
    logic         o;
    logic [W:0]   e;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rs;
    int           dones;
    int           unstable;
    int           done_t[$];
    logic [W-1:0] hold_r;
    logic         hold_o;

    total = 0;
    bad   = 0;

    vecs[0] = '{8'd100, 8'd27,  1'b0, 8'h7F, 1'b0};
    vecs[1] = '{8'd100, 8'd28,  1'b0, 8'h80, 1'b1};
    vecs[2] = '{8'h80,  8'h01,  1'b1, 8'h7F, 1'b1};
    vecs[3] = '{8'd5,   8'd7,   1'b1, 8'hFE, 1'b0};
    vecs[4] = '{8'hFF,  8'h01,  1'b0, 8'h00, 1'b0};
    vecs[5] = '{8'h7F,  8'h7F,  1'b0, 8'hFE, 1'b1};
    vecs[6] = '{8'h80,  8'h80,  1'b0, 8'h00, 1'b1};
    vecs[7] = '{8'h00,  8'h80,  1'b1, 8'h80, 1'b1};
    vecs[8] = '{8'h80,  8'h7F,  1'b1, 8'h01, 1'b1};
    vecs[9] = '{8'h00,  8'h00,  1'b1, 8'h00, 1'b0};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; s = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", 32'(result), 32'd0);
    check("reset_ov", 32'(ov), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // ---------------- directed table ----------------
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].va, vecs[i].vb, vecs[i].vs, r, o);
      check($sformatf("vec%0d_result", i), 32'(r), 32'(vecs[i].exp_r));
      check($sformatf("vec%0d_ov", i), 32'(o), 32'(vecs[i].exp_o));
    end

    // Result/ov are held in IDLE.
    repeat (3) @(negedge clk);
    check("idle_hold_result", 32'(result), 32'h00);
    check("idle_hold_ov", 32'(ov), 32'd0);

    // ---------------- randomized vs model ----------------
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      rs = 1'($urandom_range(0, 1));
      exp_q.push_back(model(ra, rb, rs));
      run_op(ra, rb, rs, r, o);
      e = exp_q.pop_front();
      check("rand_result", 32'(r), 32'(e[W-1:0]));
      check("rand_ov", 32'(o), 32'(e[W]));
    end

    // ---------------- start ignored while busy ----------------
    a = 8'd1; b = 8'd1; s = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 8'h7F; b = 8'h7F; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 8'h55; b = 8'hAA; s = 1'b1;
    dones = 0;
    r = '0; o = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        dones++;
        r = result;
        o = ov;
      end
      @(negedge clk);
    end
    check("ignore_done_count", 32'(dones), 32'd1);
    check("ignore_result", 32'(r), 32'h02);
    check("ignore_ov", 32'(o), 32'd0);
    check("ignore_idle_busy", 32'(busy), 32'd0);

    // ---------------- async reset mid-operation ----------------
    run_op(8'h7F, 8'h7F, 1'b0, r, o);  // leave result/ov non-zero
    a = 8'd100; b = 8'd28; s = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_result", 32'(result), 32'd0);
    check("arst_ov", 32'(ov), 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    check("arst_no_done", 32'(dones), 32'd0);
    run_op(8'hFF, 8'h01, 1'b0, r, o);
    check("post_rst_result", 32'(r), 32'h00);
    check("post_rst_ov", 32'(o), 32'd0);

    // ---------------- back-to-back, start held high ----------------
    // 0xFF + 0 keeps result 0xFF through every shift, so it must be stable.
    a = 8'hFF; b = 8'h00; s = 1'b0; start = 1'b1;
    unstable = 0;
    hold_r = '0;
    hold_o = 1'b0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (done) begin
        done_t.push_back(i);
        hold_r = result;
        hold_o = ov;
      end
      if (done_t.size() > 0 && (result !== 8'hFF || ov !== 1'b0)) unstable++;
    end
    start = 1'b0;
    check("b2b_done_count", 32'(done_t.size()), 32'd4);
    check("b2b_first_result", 32'(hold_r), 32'hFF);
    check("b2b_first_ov", 32'(hold_o), 32'd0);
    check("b2b_unstable", 32'(unstable), 32'd0);
    for (int i = 1; i < done_t.size(); i++) begin
      check("b2b_period", 32'(done_t[i] - done_t[i-1]), 32'(W + 2));
    end
    repeat (12) @(negedge clk);
    check("b2b_final_idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_addsub_ov.md
Name: serial_addsub_ov

Overview:
- Bit-serial two's-complement adder/subtractor with a registered signed-overflow flag.
- Produces the sign and overflow results that the combinational overflow detector checks: same operand convention (a, b, s; s=1 means a-b).
- Used in the lab datapath where area matters more than latency.
- Start/done handshake; one result bit per clock, LSB first.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
clk  input  1  system clock; all state changes on rising edge.
rst  input  1  asynchronous active-high reset.
start  input  1  request a new operation; sampled only in IDLE.
a  input  WIDTH  signed minuend/addend; captured on the accepted start edge.
b  input  WIDTH  signed subtrahend/addend; captured on the accepted start edge.
s  input  1  operation select: 0 = a+b, 1 = a-b; captured on the accepted start edge.
busy  output  1  high while in SHIFT state.
done  output  1  one-cycle pulse; result and ov are valid from this cycle.
result  output  WIDTH  two's-complement result, modulo 2^WIDTH.
ov  output  1  signed overflow of the last completed operation.

Behaviour:
- Reset (asynchronous, any state, including mid-operation):
  - State goes to IDLE.
  - busy=0, done=0, result=0, ov=0.
  - Operand shift registers, carry and bit counter cleared.
  - Any operation in flight is abandoned; no done pulse is produced for it.
- Internal state: opA and opB shift registers (WIDTH bits each), carry register c, counter cnt (ceil(log2(WIDTH)) bits), state register.
- IDLE:
  - If start=1 at a rising edge: opA<=a; opB<=(s ? ~b : b); c<=s; cnt<=0; go to SHIFT.
  - result and ov are held (not cleared), so they stay readable until the next operation.
  - If start=0: remain in IDLE.
- SHIFT (busy=1), on each edge:
  - sum bit = opA[0] ^ opB[0] ^ c.
  - result is shifted right by one, with the sum bit entering at the MSB.
  - c <= majority(opA[0], opB[0], c).
  - opA and opB are shifted right by one.
  - cnt increments.
  - On the edge where cnt==WIDTH-1 (the MSB step):
    - ov <= c_in_msb XOR c_out_msb, where c_in_msb is the current c and c_out_msb is the carry computed this step.
    - go to DONE.
- DONE:
  - done=1 and busy=0 for exactly one cycle.
  - The next edge returns to IDLE unconditionally.
  - start is ignored in DONE.
- start is ignored in SHIFT: operands are not re-captured and the operation runs to completion.
- Latency: start accepted at edge E0; bits are processed on edges E1..EWIDTH; done is high in the cycle following edge EWIDTH.
  - Back-to-back throughput: one operation per WIDTH+2 cycles (start may be asserted in the IDLE cycle after DONE).
- Arithmetic:
  - result equals (a + b) mod 2^WIDTH, or (a - b) mod 2^WIDTH when s=1.
  - ov=1 exactly when the true signed result lies outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - Equivalently, ov=1 when operands of equal effective sign (b inverted when s=1) yield a result of opposite sign.
- Unsigned carry-out is not exported.
- Input changes on a, b and s after capture have no effect on the operation in flight.

Test Plan:
- WIDTH=8, a=100, b=27, s=0, start pulse -> busy high 8 cycles; done pulse after edge E8; result=0x7F, ov=0.
- a=100, b=28, s=0 -> result=0x80, ov=1 (positive overflow).
- a=0x80 (-128), b=1, s=1 -> result=0x7F, ov=1 (negative overflow on subtract); also a=5, b=7, s=1 -> result=0xFE, ov=0.
- Start a=1, b=1, s=0. At cycle 3, pulse start with a=0x7F, b=0x7F, and change a and b -> second start ignored; result=0x02, ov=0; exactly one done pulse.
- Start a=100, b=28. Assert rst asynchronously (between clock edges) at cycle 4 -> busy, done, result and ov go to 0 immediately; no done pulse follows. After rst deasserts, a new operation a=0xFF, b=0x01, s=0 -> result=0x00, ov=0.
- Back-to-back: start held high continuously -> operations start every 10 cycles; result and ov remain stable between done pulses.
